// File: rtl/mont_modexp.sv
// Montgomery modular exponentiation, LSB-first square-and-multiply over MOD with radix 2^WIDTH.
// Optional macro MONT_MODEXP_EARLY_EXIT_EN ends the bit loop once the remaining exponent is zero.
module mont_modexp #(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] MOD    = 998244353,
  parameter logic [WIDTH-1:0] NPRIME = 998244351,
  parameter logic [WIDTH-1:0] R2MOD  = 932051910
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONV  = 3'd1;
  localparam logic [2:0] S_LOOP  = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_accM;
  logic [WIDTH-1:0] r_bM;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

`ifndef MONT_MODEXP_EARLY_EXIT_EN
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [CW-1:0] r_cnt;
`endif

  logic [WIDTH-1:0] w_aOp1;
  logic [WIDTH-1:0] w_aOp2;
  logic [WIDTH-1:0] w_bOp1;
  logic [WIDTH-1:0] w_bOp2;
  logic [WIDTH-1:0] w_mulA;
  logic [WIDTH-1:0] w_mulB;

  // REDC(a*b); the sum t + m*MOD needs one extra bit above 2*WIDTH.
  function automatic logic [WIDTH-1:0] mm(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] t;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH:0]   s;
    logic [WIDTH:0]     u;
    logic [WIDTH:0]     d;
    t = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    m = t[WIDTH-1:0] * NPRIME;
    s = {1'b0, t} + ({{(WIDTH+1){1'b0}}, m} * {{(WIDTH+1){1'b0}}, MOD});
    u = s[2*WIDTH:WIDTH];
    d = u - {1'b0, MOD};
    if (u >= {1'b0, MOD}) begin
      return d[WIDTH-1:0];
    end
    return u[WIDTH-1:0];
  endfunction

  // Unit A carries the accumulator, unit B the running base power.
  always_comb begin
    w_aOp1 = r_accM;
    w_aOp2 = r_bM;
    w_bOp1 = r_bM;
    w_bOp2 = r_bM;
    case (r_state)
      S_CONV: begin
        w_aOp1 = ONE;
        w_aOp2 = R2MOD;
        w_bOp1 = r_base;
        w_bOp2 = R2MOD;
      end
      S_FINAL: begin
        w_aOp1 = r_accM;
        w_aOp2 = ONE;
      end
      default: ;
    endcase
  end

  assign w_mulA = mm(w_aOp1, w_aOp2);
  assign w_mulB = mm(w_bOp1, w_bOp2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_exp    <= '0;
      r_accM   <= '0;
      r_bM     <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
`ifndef MONT_MODEXP_EARLY_EXIT_EN
      r_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_base  <= base;
            r_exp   <= exp;
            r_done  <= 1'b0;
            r_state <= S_CONV;
`ifndef MONT_MODEXP_EARLY_EXIT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_CONV: begin
          r_accM  <= w_mulA;
          r_bM    <= w_mulB;
          r_state <= S_LOOP;
        end
        S_LOOP: begin
`ifdef MONT_MODEXP_EARLY_EXIT_EN
          if (r_exp == '0) begin
            r_state <= S_FINAL;
          end else begin
            if (r_exp[0]) begin
              r_accM <= w_mulA;
            end
            r_bM  <= w_mulB;
            r_exp <= r_exp >> 1;
          end
`else
          if (r_exp[0]) begin
            r_accM <= w_mulA;
          end
          r_bM  <= w_mulB;
          r_exp <= r_exp >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= S_FINAL;
          end
`endif
        end
        S_FINAL: begin
          r_result <= w_mulA;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_mont_modexp.sv
// Self-checking bench for mont_modexp: fixed vectors, corner sequences and random pairs
// compared against a plain square-and-multiply reference.
module tb_mont_modexp;

  localparam longint unsigned MODV = 64'd998244353;

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [31:0] exp;
    logic [31:0] want;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base;
  logic [31:0] exp;
  logic        done;
  logic [31:0] result;

  int vecCount  = 0;
  int missCount = 0;

  mont_modexp dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .base   (base),
    .exp    (exp),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refModexp(input logic [31:0] b, input logic [31:0] e);
    longint unsigned acc = 1;
    longint unsigned x;
    x = longint'(b) % MODV;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) acc = (acc * x) % MODV;
      x = (x * x) % MODV;
    end
    return acc[31:0];
  endfunction

  function automatic int expLatency(input logic [31:0] e);
`ifdef MONT_MODEXP_EARLY_EXIT_EN
    int n = 0;
    for (int i = 0; i < 32; i++) if (e[i]) n = i + 1;
    return 3 + n;
`else
    return 34;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Returns edges counted from the accepting edge until done is seen (bounded).
  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] e, output int edges);
    @(negedge clk);
    base  = b;
    exp   = e;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("done cleared on accept", {31'b0, done}, 32'd0);
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
    end
  endtask

  task automatic runVector(input string name, input logic [31:0] b, input logic [31:0] e,
                           input logic [31:0] want);
    int edges;
    applyStimulus(b, e, edges);
    checkOutput({name, " latency"}, edges, expLatency(e));
    checkOutput({name, " result"}, result, want);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, " done held"}, {31'b0, done}, 32'd1);
    checkOutput({name, " result held"}, result, want);
  endtask

  initial begin
    vec_t vecs[7];
    int   edges;
    logic [31:0] rb, re;

    vecs[0] = '{"b2e0",     32'd2,          32'd0,  32'd1};
    vecs[1] = '{"b2e2",     32'd2,          32'd2,  32'd4};
    vecs[2] = '{"b5e13",    32'd5,          32'd13, 32'd222458772};
    vecs[3] = '{"bm1e2",    32'd998244352,  32'd2,  32'd1};
    vecs[4] = '{"bm1e3",    32'd998244352,  32'd3,  32'd998244352};
    vecs[5] = '{"bmaxe1",   32'hFFFFFFFF,   32'd1,  32'd301989883};
    vecs[6] = '{"bmode5",   32'd998244353,  32'd5,  32'd0};

    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    exp   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      runVector(vecs[i].name, vecs[i].base, vecs[i].exp, vecs[i].want);
    end

    // Reset in the middle of the bit loop must abort and keep done low.
    @(negedge clk);
    base  = 32'd3;
    exp   = 32'hDEADBEEF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midloop rst done", {31'b0, done}, 32'd0);
    checkOutput("midloop rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("after rst done low", {31'b0, done}, 32'd0);
    runVector("after rst b2e1", 32'd2, 32'd1, 32'd2);

    // A second start inside the loop is ignored.
    @(negedge clk);
    base  = 32'd5;
    exp   = 32'd13;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 0;
    repeat (2) begin
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    base  = 32'd7;
    exp   = 32'd9;
    start = 1'b1;
    @(posedge clk);
    edges++;
    #1 start = 1'b0;
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
    end
    checkOutput("ignored start latency", edges, expLatency(32'd13));
    checkOutput("ignored start result", result, 32'd222458772);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    base  = 32'd2;
    exp   = 32'd2;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("rst over start done", {31'b0, done}, 32'd0);
    checkOutput("rst over start result", result, 32'd0);

    for (int i = 0; i < 20; i++) begin
      rb = $urandom;
      re = (i < 10) ? $urandom : $urandom_range(0, 255);
      runVector($sformatf("rand%0d", i), rb, re, refModexp(rb, re));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
